prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Hardware program/data loader for the pipelined CPU. It is the writer side of the instruction and data memories, which the CPU and debug paths read.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes each word into instruction memory or data memory, then asserts start_o to release the CPU.
- Replaces bench-side memory preloading and sits between the host link and the CPU top.

Parameters:
- IMEM_WORDS, 256, instruction memory depth in 32-bit words.
- DMEM_BYTES, 32, data memory size in bytes (word-addressed writes, byte address output).
- IMEM_AW, $clog2(IMEM_WORDS), derived IMEM word-address width.
- DMEM_AW, $clog2(DMEM_BYTES), derived DMEM byte-address width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- byte_valid_i  in  1  input byte valid.
- byte_i  in  8  input byte.
- byte_ready_o  out  1  loader can accept a byte.
- imem_we_o  out  1  IMEM write strobe, one-cycle pulse.
- imem_addr_o  out  IMEM_AW  IMEM word address.
- imem_data_o  out  32  IMEM write data.
- dmem_we_o  out  1  DMEM word write strobe, one-cycle pulse.
- dmem_addr_o  out  DMEM_AW  DMEM byte address, word aligned.
- dmem_data_o  out  32  DMEM write data; byte 0 goes to the lowest address.
- start_o  out  1  CPU start, sticky once set.
- err_o  out  1  protocol error, sticky.
- words_loaded_o  out  16  total words written since reset.

Behaviour:
- Handshake: a byte transfers in a cycle where byte_valid_i && byte_ready_o. byte_ready_o = 1 in IDLE, BASE, LEN0, LEN1 and DATA; 0 in DONE and ERR.
- Block format: CMD, BASE, CNT_LO, CNT_HI, then 4*CNT data bytes, little-endian per word.
  - CMD 0x00 selects IMEM; 0x01 selects DMEM.
  - CMD 0xFF means END.
  - Any other CMD value is an error.
- FSM states: IDLE, BASE, LEN0, LEN1, DATA, DONE, ERR.
  - IDLE: on CMD 0x00/0x01, latch the target and go to BASE. On 0xFF go to DONE. On any other value go to ERR.
  - BASE: latch the base word index (8 bit) and go to LEN0.
  - LEN0: latch the count low byte and go to LEN1.
  - LEN1: latch the count high byte, then range-check:
    - Limit is IMEM_WORDS for IMEM, DMEM_BYTES/4 for DMEM.
    - If base + cnt > limit (17-bit compare), go to ERR with no writes performed.
    - If cnt == 0, go to IDLE.
    - Otherwise go to DATA with byte_idx = 0.
  - DATA: shift the byte into the word register at position byte_idx.
    - On byte_idx == 3, issue a write the next cycle and increment the address and words_loaded_o.
    - On the last byte of the last word, go to IDLE.
  - DONE: assert start_o and hold it; ignore all input (ready low).
  - ERR: assert err_o; start_o never asserts; stay here until reset.
- Write latency: the we pulse is asserted exactly 1 cycle after the 4th byte of a word is accepted. Addr/data are stable during the pulse.
- Back-to-back: one byte per cycle is sustained; the loader never stalls the stream during a block.
- Address rules:
  - IMEM: addr = base + word_i.
  - DMEM: addr = (base + word_i) * 4.
  - Widths are truncated after the range check, so no wrap can occur.
- words_loaded_o saturates at 0xFFFF.
- Reset values: all outputs 0, FSM in IDLE, ready = 1 in the first cycle after reset deassertion.
- Reset mid-block: data in flight is abandoned, no pending write is issued, and counters are cleared.
- Idle gaps (valid low) are legal in every state and do not change state.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- Defined:
  - Each non-END block carries one extra trailing byte equal to the XOR of all preceding bytes of that block, CMD included.
  - A state CSUM follows the last data byte (or LEN1 when cnt == 0). Match goes to IDLE; mismatch goes to ERR.
  - Writes already issued for the block are not undone.
- Undefined: no trailing byte; the block ends after the data bytes.

Decomposition:
- Package prog_loader_pkg:
  - State enum.
  - CMD constants CMD_IMEM = 8'h00, CMD_DMEM = 8'h01, CMD_END = 8'hFF.
- Sub-module word_assembler: byte-to-word shifter with byte_idx counter, word_valid pulse and clear input. Reusable by future host-link blocks.

Test Plan:
- IMEM block (00, 00, 02, 00, 78 56 34 12, EF BE AD DE), then END → imem_we pulses twice: addr 0 with 0x12345678, addr 1 with 0xDEADBEEF. start_o = 1 two cycles after END is accepted; words_loaded_o = 2.
- DMEM block (01, 00, 01, 00, 05 00 00 00) → dmem_we with addr 0 and data 0x00000005; start_o remains 0 until END.
- Range error: IMEM base 0xFF, cnt 2 → err_o = 1 after CNT_HI, zero writes, ready low; END is ignored afterwards.
- Invalid CMD 0x42 → err_o = 1 and ready = 0; reset clears it and a subsequent valid stream loads normally.
- Gaps and reset mid-word: valid toggled randomly gives results identical to scenario 1. Reset after 2 data bytes gives no write, words_loaded_o = 0, FSM in IDLE.
- With PROG_LOADER_CHECKSUM_EN, scenario 2:
  - Checksum 0x05 ^ 0x01 ^ 0x01 = 0x05 → return to IDLE.
  - Checksum 0x00 → err_o = 1, with the DMEM write already done.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared types for the program loader: FSM state encoding and block command bytes.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BASE,
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_DONE,
    ST_ERR,
    ST_CSUM
  } state_t;

  localparam logic [7:0] CMD_IMEM = 8'h00;
  localparam logic [7:0] CMD_DMEM = 8'h01;
  localparam logic [7:0] CMD_END  = 8'hFF;

endpackage

// File: rtl/prog_loader_word_assembler.sv
// Little-endian byte-to-word shifter: byte_idx selects the lane, word_valid pulses
// one cycle after the fourth byte lands.
module word_assembler (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        byte_en_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o,
  output logic [1:0]  byte_idx_o
);

  logic [1:0] byte_idx_reg;
  logic       word_valid_reg;
  logic       take;

  assign take = byte_en_i && !clear_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      byte_idx_reg   <= '0;
      word_valid_reg <= 1'b0;
    end else begin
      word_valid_reg <= take && (byte_idx_reg == 2'd3);
      if (clear_i)
        byte_idx_reg <= '0;
      else if (byte_en_i)
        byte_idx_reg <= byte_idx_reg + 2'd1;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_reg;
    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)
        lane_reg <= '0;
      else if (take && (byte_idx_reg == 2'(gi)))
        lane_reg <= byte_i;
    end
    assign word_o[8*gi +: 8] = lane_reg;
  end

  assign word_valid_o = word_valid_reg;
  assign byte_idx_o   = byte_idx_reg;

endmodule

// File: rtl/prog_loader.sv
// Byte-stream loader writing IMEM/DMEM words, then releasing the CPU via start_o.
// Optional trailing per-block XOR checksum: define PROG_LOADER_CHECKSUM_EN.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_BYTES = 32,
  parameter int IMEM_AW    = $clog2(IMEM_WORDS),
  parameter int DMEM_AW    = $clog2(DMEM_BYTES)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               byte_valid_i,
  input  logic [7:0]         byte_i,
  output logic               byte_ready_o,
  output logic               imem_we_o,
  output logic [IMEM_AW-1:0] imem_addr_o,
  output logic [31:0]        imem_data_o,
  output logic               dmem_we_o,
  output logic [DMEM_AW-1:0] dmem_addr_o,
  output logic [31:0]        dmem_data_o,
  output logic               start_o,
  output logic               err_o,
  output logic [15:0]        words_loaded_o
);

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_t BLOCK_END = ST_CSUM;
`else
  localparam state_t BLOCK_END = ST_IDLE;
`endif

  state_t             state_reg, state_next;
  logic               byte_ready, accept;
  logic               tgt_dmem_reg;
  logic [7:0]         base_reg, cnt_lo_reg;
  logic [15:0]        words_left_reg, words_loaded_reg;
  logic [IMEM_AW-1:0] word_ptr_reg;
  logic               start_reg, err_reg;
  logic [15:0]        cnt_full;
  logic [16:0]        range_sum, range_limit;
  logic               range_bad, last_byte;
  logic [31:0]        wa_word;
  logic               wa_valid, wa_clear, wa_en;
  logic [1:0]         wa_idx;

  assign accept      = byte_valid_i && byte_ready;
  assign cnt_full    = {byte_i, cnt_lo_reg};
  assign range_sum   = 17'(base_reg) + 17'(cnt_full);
  assign range_limit = tgt_dmem_reg ? 17'(DMEM_BYTES / 4) : 17'(IMEM_WORDS);
  assign range_bad   = range_sum > range_limit;
  assign last_byte   = (wa_idx == 2'd3) && (words_left_reg == 16'd1);
  assign wa_clear    = accept && (state_reg == ST_LEN1);
  assign wa_en       = accept && (state_reg == ST_DATA);

  word_assembler u_asm (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clear_i      (wa_clear),
    .byte_en_i    (wa_en),
    .byte_i       (byte_i),
    .word_o       (wa_word),
    .word_valid_o (wa_valid),
    .byte_idx_o   (wa_idx)
  );

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] csum_reg;
  // The CMD byte restarts the running XOR for each block.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      csum_reg <= '0;
    else if (accept)
      csum_reg <= (state_reg == ST_IDLE) ? byte_i : (csum_reg ^ byte_i);
  end
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      state_reg <= ST_IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (accept) begin
        if (byte_i == CMD_IMEM || byte_i == CMD_DMEM) state_next = ST_BASE;
        else if (byte_i == CMD_END)                   state_next = ST_DONE;
        else                                          state_next = ST_ERR;
      end
      ST_BASE: if (accept) state_next = ST_LEN0;
      ST_LEN0: if (accept) state_next = ST_LEN1;
      ST_LEN1: if (accept) begin
        if (range_bad)             state_next = ST_ERR;
        else if (cnt_full == 16'd0) state_next = BLOCK_END;
        else                       state_next = ST_DATA;
      end
      ST_DATA: if (accept && last_byte) state_next = BLOCK_END;
`ifdef PROG_LOADER_CHECKSUM_EN
      ST_CSUM: if (accept) state_next = (byte_i == csum_reg) ? ST_IDLE : ST_ERR;
`endif
      default: state_next = state_reg;
    endcase
  end

  always_comb begin
    byte_ready = 1'b1;
    case (state_reg)
      ST_DONE, ST_ERR: byte_ready = 1'b0;
      default:         byte_ready = 1'b1;
    endcase
  end

  // The write pulse lands in the cycle after the fourth byte, so the address
  // pointer advances on the pulse itself and stays stable while it is high.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      tgt_dmem_reg     <= 1'b0;
      base_reg         <= '0;
      cnt_lo_reg       <= '0;
      words_left_reg   <= '0;
      word_ptr_reg     <= '0;
      words_loaded_reg <= '0;
      start_reg        <= 1'b0;
      err_reg          <= 1'b0;
    end else begin
      start_reg <= start_reg || (state_reg == ST_DONE);
      err_reg   <= err_reg || (state_reg == ST_ERR);
      if (accept) begin
        case (state_reg)
          ST_IDLE: tgt_dmem_reg <= (byte_i == CMD_DMEM);
          ST_BASE: base_reg     <= byte_i;
          ST_LEN0: cnt_lo_reg   <= byte_i;
          ST_LEN1: begin
            words_left_reg <= cnt_full;
            word_ptr_reg   <= IMEM_AW'(base_reg);
          end
          ST_DATA: if (wa_idx == 2'd3) words_left_reg <= words_left_reg - 16'd1;
          default: ;
        endcase
      end
      if (wa_valid) begin
        word_ptr_reg <= word_ptr_reg + 1'b1;
        if (words_loaded_reg != 16'hFFFF)
          words_loaded_reg <= words_loaded_reg + 16'd1;
      end
    end
  end

  assign byte_ready_o   = byte_ready;
  assign imem_we_o      = wa_valid && !tgt_dmem_reg;
  assign dmem_we_o      = wa_valid && tgt_dmem_reg;
  assign imem_addr_o    = word_ptr_reg;
  assign dmem_addr_o    = {word_ptr_reg[DMEM_AW-3:0], 2'b00};
  assign imem_data_o    = wa_word;
  assign dmem_data_o    = wa_word;
  assign start_o        = start_reg;
  assign err_o          = err_reg;
  assign words_loaded_o = words_loaded_reg;

endmodule

// File: tb/tb_prog_loader.sv
// Randomised bench for prog_loader: a block-level stream parser predicts every write,
// the ready/start/err flags and the word count, and a per-cycle monitor compares.
module tb_prog_loader;
  import prog_loader_pkg::*;

  localparam int IMEM_WORDS = 256;
  localparam int DMEM_BYTES = 32;
  localparam int IMEM_AW    = 8;
  localparam int DMEM_AW    = 5;
  localparam int MAXS       = 2048;

  logic               clk_i = 1'b0;
  logic               rst_i = 1'b1;
  logic               byte_valid_i = 1'b0;
  logic [7:0]         byte_i = 8'h00;
  logic               byte_ready_o;
  logic               imem_we_o;
  logic [IMEM_AW-1:0] imem_addr_o;
  logic [31:0]        imem_data_o;
  logic               dmem_we_o;
  logic [DMEM_AW-1:0] dmem_addr_o;
  logic [31:0]        dmem_data_o;
  logic               start_o;
  logic               err_o;
  logic [15:0]        words_loaded_o;

  prog_loader #(.IMEM_WORDS(IMEM_WORDS), .DMEM_BYTES(DMEM_BYTES)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .byte_valid_i   (byte_valid_i),
    .byte_i         (byte_i),
    .byte_ready_o   (byte_ready_o),
    .imem_we_o      (imem_we_o),
    .imem_addr_o    (imem_addr_o),
    .imem_data_o    (imem_data_o),
    .dmem_we_o      (dmem_we_o),
    .dmem_addr_o    (dmem_addr_o),
    .dmem_data_o    (dmem_data_o),
    .start_o        (start_o),
    .err_o          (err_o),
    .words_loaded_o (words_loaded_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Stream under test and its block-level interpretation
  logic [7:0]  stream[$];
  logic [31:0] blk_words[$];
  int          wr_kind[MAXS];   // 0 none, 1 IMEM, 2 DMEM write after this byte
  logic [31:0] wr_addr[MAXS];
  logic [31:0] wr_data[MAXS];
  int          stop_idx;        // byte after which the loader stops accepting
  int          stop_kind;       // 1 END, 2 error

  // Model state
  int          p, n_acc;
  bit          m_stopped, m_start, m_err, start_pend, err_pend;
  int          m_we, m_words;
  logic [31:0] m_addr, m_data;
  bit          chk_en = 1'b0;

  // Observed writes, for hand-computed expectations
  int          log_kind[$];
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];

  task automatic add_block(input logic [7:0] cmd, input logic [7:0] base, input logic [15:0] cnt);
    logic [7:0]  x;
    logic [31:0] d;
    x = cmd ^ base ^ cnt[7:0] ^ cnt[15:8];
    stream.push_back(cmd);
    stream.push_back(base);
    stream.push_back(cnt[7:0]);
    stream.push_back(cnt[15:8]);
    for (int w = 0; w < int'(cnt); w++) begin
      d = (w < blk_words.size()) ? blk_words[w] : $urandom;
      for (int b = 0; b < 4; b++) begin
        stream.push_back(d[8*b +: 8]);
        x = x ^ d[8*b +: 8];
      end
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    stream.push_back(x);
`endif
    blk_words.delete();
  endtask

  function automatic void parse();
    int i, n, j, ib, ic, lim;
    logic [7:0] c, x;
    for (int k = 0; k < MAXS; k++) wr_kind[k] = 0;
    stop_idx  = -1;
    stop_kind = 0;
    n = stream.size();
    i = 0;
    while (i < n) begin
      c = stream[i];
      if (c == CMD_END) begin stop_idx = i; stop_kind = 1; return; end
      if (c != CMD_IMEM && c != CMD_DMEM) begin stop_idx = i; stop_kind = 2; return; end
      if (i + 3 >= n) return;
      ib  = int'(stream[i+1]);
      ic  = int'({stream[i+3], stream[i+2]});
      lim = (c == CMD_DMEM) ? DMEM_BYTES / 4 : IMEM_WORDS;
      if (ib + ic > lim) begin stop_idx = i + 3; stop_kind = 2; return; end
      x = c ^ stream[i+1] ^ stream[i+2] ^ stream[i+3];
      for (int w = 0; w < ic; w++) begin
        j = i + 4 + 4 * w;
        if (j + 3 >= n) return;
        x = x ^ stream[j] ^ stream[j+1] ^ stream[j+2] ^ stream[j+3];
        wr_kind[j+3] = (c == CMD_DMEM) ? 2 : 1;
        wr_addr[j+3] = (c == CMD_DMEM) ? 32'(((ib + w) * 4) % DMEM_BYTES)
                                       : 32'((ib + w) % IMEM_WORDS);
        wr_data[j+3] = {stream[j+3], stream[j+2], stream[j+1], stream[j]};
      end
      i = i + 4 + 4 * ic;
`ifdef PROG_LOADER_CHECKSUM_EN
      if (i >= n) return;
      if (stream[i] != x) begin stop_idx = i; stop_kind = 2; return; end
      i++;
`endif
    end
  endfunction

  function automatic void model_step();
    if (m_we != 0 && m_words < 65535) m_words++;
    m_we = 0;
    if (start_pend) m_start = 1'b1;
    if (err_pend)   m_err   = 1'b1;
    start_pend = 1'b0;
    err_pend   = 1'b0;
    if (byte_valid_i) begin
      if (!m_stopped) begin
        if (wr_kind[p] != 0) begin
          m_we   = wr_kind[p];
          m_addr = wr_addr[p];
          m_data = wr_data[p];
        end
        if (p == stop_idx) begin
          m_stopped = 1'b1;
          if (stop_kind == 1) start_pend = 1'b1;
          else                err_pend   = 1'b1;
        end
        n_acc++;
      end
      p++;  // a refused byte is dropped by the host after one cycle
    end
  endfunction

  task automatic tick(input bit want_valid);
    byte_valid_i = want_valid && (p < stream.size());
    byte_i       = byte_valid_i ? stream[p] : 8'($urandom);
    @(posedge clk_i);
    if (rst_i) model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_i        = 1'b0;
    byte_valid_i = 1'b0;
    m_stopped = 0; m_start = 0; m_err = 0; start_pend = 0; err_pend = 0;
    m_we = 0; m_words = 0; m_addr = '0; m_data = '0; p = 0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
  endtask

  task automatic new_stream();
    stream.delete();
    blk_words.delete();
    log_kind.delete();
    log_addr.delete();
    log_data.delete();
  endtask

  // Present the stream with the given idle-gap percentage; stop early after
  // max_acc accepted bytes when max_acc >= 0.
  task automatic run_stream(input int gap_pct, input int max_acc);
    int budget;
    parse();
    p = 0; n_acc = 0; budget = 0;
    while (p < stream.size() && budget < 20000) begin
      tick($urandom_range(0, 99) >= gap_pct);
      budget++;
      if (max_acc >= 0 && n_acc >= max_acc) break;
    end
    if (budget >= 20000) check("stream_budget", 32'(budget), 32'(0));
    if (max_acc < 0) repeat (4) tick(1'b0);
  endtask

  task automatic build_s1();
    blk_words.push_back(32'h12345678);
    blk_words.push_back(32'hDEADBEEF);
    add_block(CMD_IMEM, 8'h00, 16'd2);
    stream.push_back(CMD_END);
  endtask

  always @(negedge clk_i) begin
    if (chk_en) begin
      check("ready",   32'(byte_ready_o), 32'(!m_stopped));
      check("imem_we", 32'(imem_we_o), 32'(m_we == 1));
      check("dmem_we", 32'(dmem_we_o), 32'(m_we == 2));
      if (m_we == 1) begin
        check("imem_addr", 32'(imem_addr_o), m_addr);
        check("imem_data", imem_data_o, m_data);
      end
      if (m_we == 2) begin
        check("dmem_addr", 32'(dmem_addr_o), m_addr);
        check("dmem_data", dmem_data_o, m_data);
      end
      check("start", 32'(start_o), 32'(m_start));
      check("err",   32'(err_o),   32'(m_err));
      check("words", 32'(words_loaded_o), 32'(m_words));
      if (imem_we_o) begin
        log_kind.push_back(1); log_addr.push_back(32'(imem_addr_o)); log_data.push_back(imem_data_o);
        $display("write imem addr=0x%0h data=0x%08h", imem_addr_o, imem_data_o);
      end
      if (dmem_we_o) begin
        log_kind.push_back(2); log_addr.push_back(32'(dmem_addr_o)); log_data.push_back(dmem_data_o);
        $display("write dmem addr=0x%0h data=0x%08h", dmem_addr_o, dmem_data_o);
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] base, cmd;
    logic [15:0] cnt;
    int nb, r, t;
    #1;
    chk_en = 1'b1;
    do_reset();
    check("rst_ready", 32'(byte_ready_o), 32'd1);
    check("rst_start", 32'(start_o), 32'd0);
    check("rst_words", 32'(words_loaded_o), 32'd0);

    // Scenario 1: two IMEM words, then END, no gaps
    new_stream(); build_s1(); run_stream(0, -1);
    check("s1_nwr",   32'(log_kind.size()), 32'd2);
    check("s1_a0",    log_addr[0], 32'h0);
    check("s1_d0",    log_data[0], 32'h12345678);
    check("s1_a1",    log_addr[1], 32'h1);
    check("s1_d1",    log_data[1], 32'hDEADBEEF);
    check("s1_start", 32'(start_o), 32'd1);
    check("s1_words", 32'(words_loaded_o), 32'd2);

    // Scenario 2: one DMEM word; start only after END
    do_reset(); new_stream();
    blk_words.push_back(32'h00000005);
    add_block(CMD_DMEM, 8'h00, 16'd1);
    run_stream(0, -1);
    check("s2_kind",  32'(log_kind[0]), 32'd2);
    check("s2_addr",  log_addr[0], 32'h0);
    check("s2_data",  log_data[0], 32'h5);
    check("s2_nostart", 32'(start_o), 32'd0);
    new_stream(); stream.push_back(CMD_END); run_stream(0, -1);
    check("s2_start", 32'(start_o), 32'd1);

    // DMEM top word and IMEM top words sit exactly at the limit
    do_reset(); new_stream();
    blk_words.push_back(32'hCAFEF00D);
    add_block(CMD_DMEM, 8'h07, 16'd1);
    add_block(CMD_IMEM, 8'hFE, 16'd2);
    stream.push_back(CMD_END);
    run_stream(30, -1);
    check("lim_daddr", log_addr[0], 32'h1C);
    check("lim_ddata", log_data[0], 32'hCAFEF00D);
    check("lim_iaddr", log_addr[2], 32'hFF);
    check("lim_err",   32'(err_o), 32'd0);

    // Scenario 3: range error, END afterwards ignored
    do_reset(); new_stream();
    add_block(CMD_IMEM, 8'hFF, 16'd2);
    stream.push_back(CMD_END);
    run_stream(0, -1);
    check("s3_err",   32'(err_o), 32'd1);
    check("s3_nwr",   32'(log_kind.size()), 32'd0);
    check("s3_ready", 32'(byte_ready_o), 32'd0);
    check("s3_start", 32'(start_o), 32'd0);

    // Count high byte participates in the range check (257 > 256)
    do_reset(); new_stream();
    stream.push_back(8'h00); stream.push_back(8'h00);
    stream.push_back(8'h01); stream.push_back(8'h01);
    stream.push_back(CMD_END);
    run_stream(0, -1);
    check("s3b_err", 32'(err_o), 32'd1);

    // Scenario 4: invalid command, then reset and a gappy reload
    do_reset(); new_stream();
    stream.push_back(8'h42); stream.push_back(CMD_END);
    run_stream(0, -1);
    check("s4_err",   32'(err_o), 32'd1);
    check("s4_ready", 32'(byte_ready_o), 32'd0);
    do_reset();
    check("s4_rst_err", 32'(err_o), 32'd0);
    new_stream(); build_s1(); run_stream(40, -1);
    check("s4_d1",    log_data[1], 32'hDEADBEEF);
    check("s4_words", 32'(words_loaded_o), 32'd2);
    check("s4_start", 32'(start_o), 32'd1);

    // Scenario 5: reset after two data bytes abandons the word
    do_reset(); new_stream(); build_s1();
    run_stream(0, 6);
    do_reset();
    repeat (3) tick(1'b0);
    check("s5_nwr",   32'(log_kind.size()), 32'd0);
    check("s5_words", 32'(words_loaded_o), 32'd0);
    check("s5_ready", 32'(byte_ready_o), 32'd1);
    new_stream(); stream.push_back(CMD_END); run_stream(0, -1);
    check("s5_idle_end", 32'(start_o), 32'd1);

`ifdef PROG_LOADER_CHECKSUM_EN
    // Bad checksum: the DMEM write stays done, err rises
    do_reset(); new_stream();
    stream.push_back(8'h01); stream.push_back(8'h00); stream.push_back(8'h01); stream.push_back(8'h00);
    stream.push_back(8'h05); stream.push_back(8'h00); stream.push_back(8'h00); stream.push_back(8'h00);
    stream.push_back(8'h00);
    run_stream(0, -1);
    check("cs_err",  32'(err_o), 32'd1);
    check("cs_nwr",  32'(log_kind.size()), 32'd1);
    check("cs_data", log_data[0], 32'h5);
`endif

    // Randomised block streams
    for (int it = 0; it < 25; it++) begin
      do_reset(); new_stream();
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) begin
        r   = $urandom_range(0, 99);
        cmd = ($urandom_range(0, 1) != 0) ? CMD_DMEM : CMD_IMEM;
        if (r < 70) begin
          if (cmd == CMD_DMEM) begin cnt = 16'($urandom_range(1, 8)); base = 8'($urandom_range(0, 8 - int'(cnt))); end
          else begin cnt = 16'($urandom_range(1, 6)); base = 8'($urandom_range(0, 256 - int'(cnt))); end
        end else if (r < 85) begin
          cnt = 16'd0; base = 8'($urandom_range(0, 255));
        end else begin
          if (cmd == CMD_DMEM) begin base = 8'($urandom_range(5, 7)); cnt = 16'($urandom_range(4, 6)); end
          else begin base = 8'($urandom_range(250, 255)); cnt = 16'($urandom_range(7, 12)); end
        end
        add_block(cmd, base, cnt);
      end
      t = $urandom_range(0, 99);
      if (t < 70)      stream.push_back(CMD_END);
      else if (t < 80) stream.push_back(8'($urandom_range(2, 254)));
      run_stream($urandom_range(0, 60), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
